sram_access_ctrl: RTL and testbench

Sequencer between the MEM stage and the board's single-port 16-bit SRAM. Turns one 32-bit load or store from the MEM stage into two timed halfword SRAM cycles. Drives `ready` low for the whole transaction so the top level can freeze the IF/ID/EXE/MEM stage registers. Returns the assembled 32-bit read word to MEM_Stage in place of the on-chip data memory.

---
 rtl/sram_access_ctrl_pkg.sv | 17 +
 rtl/sram_access_ctrl_if.sv | 56 +++++
 rtl/sram_access_ctrl_wait_timer.sv | 28 ++
 rtl/sram_access_ctrl.sv | 143 ++++++++++++++
 tb/tb_sram_access_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM sequencer.
// Optional build macro: SRAM_ALIGN_CHECK_EN (adds misalign_err).
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } sram_state_t;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    localparam logic [31:0] DEFAULT_DATA_BASE = 32'd1024;

endpackage

// File: rtl/sram_access_ctrl_if.sv
// MEM-stage request bundle plus the SRAM pad-side signals.
// Optional build macro: SRAM_ALIGN_CHECK_EN (adds misalign_err).
interface sram_access_ctrl_if
    import arm_mem_pkg::*;
();

    logic                   rd_en;
    logic                   wr_en;
    logic [31:0]            address;
    logic [31:0]            write_data;
    logic [31:0]            read_data;
    logic                   ready;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [SRAM_DATA_W-1:0] sram_dq_out;
    logic [SRAM_DATA_W-1:0] sram_dq_in;
    logic                   sram_dq_oe;
    logic                   sram_we_n;
`ifdef SRAM_ALIGN_CHECK_EN
    logic                   misalign_err;
`endif

    modport master (
        output rd_en,
        output wr_en,
        output address,
        output write_data,
        output sram_dq_in,
        input  read_data,
        input  ready,
        input  sram_addr,
        input  sram_dq_out,
        input  sram_dq_oe,
`ifdef SRAM_ALIGN_CHECK_EN
        input  misalign_err,
`endif
        input  sram_we_n
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  address,
        input  write_data,
        input  sram_dq_in,
        output read_data,
        output ready,
        output sram_addr,
        output sram_dq_out,
        output sram_dq_oe,
`ifdef SRAM_ALIGN_CHECK_EN
        output misalign_err,
`endif
        output sram_we_n
    );

endinterface

// File: rtl/sram_access_ctrl_wait_timer.sv
// Per-phase wait counter; last flags the final cycle of a phase.
// Optional build macro: SRAM_ALIGN_CHECK_EN (unused here).
module sram_wait_timer #(
    parameter int WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [3:0] count;

    // Count phase cycles; clear has priority over enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    assign last = (count == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_access_ctrl.sv
// Splits one 32-bit MEM access into two timed 16-bit SRAM cycles.
// Optional build macro: SRAM_ALIGN_CHECK_EN (misaligned access trap).
module sram_access_ctrl
    import arm_mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] DATA_BASE   = DEFAULT_DATA_BASE
) (
    input logic               clk,
    input logic               rst,
    sram_access_ctrl_if.slave bus
);

    sram_state_t state;
    sram_state_t state_nxt;

    logic        op_wr;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        req;
    logic        last;
    logic        in_phase;
    logic        misalign;
    logic [16:0] word;
    logic [31:0] rdata;

    assign req      = bus.rd_en | bus.wr_en;
    assign in_phase = (state == LOW) || (state == HIGH);
    assign word     = 17'((op_addr - DATA_BASE) >> 2);

`ifdef SRAM_ALIGN_CHECK_EN
    logic err_q;

    assign misalign = |bus.address[1:0];

    // Sticky flag for any misaligned request seen in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && req && misalign) begin
            err_q <= 1'b1;
        end
    end

    assign bus.misalign_err = err_q;
`else
    assign misalign = 1'b0;
`endif

    sram_wait_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (!in_phase || last),
        .en   (in_phase),
        .last (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operands are captured only when a request is accepted in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr    <= 1'b0;
            op_addr  <= 32'd0;
            op_wdata <= 32'd0;
        end else if (state == IDLE && req) begin
            op_wr    <= bus.wr_en;
            op_addr  <= bus.address;
            op_wdata <= bus.write_data;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = misalign ? DONE : LOW;
                end
            end
            LOW: begin
                if (last) begin
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // SRAM pins decode from registered state and latched operands only.
    always_comb begin
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        if (in_phase) begin
            bus.sram_addr = {word, state == HIGH};
            if (op_wr) begin
                bus.sram_dq_out = (state == HIGH) ? op_wdata[31:16]
                                                  : op_wdata[15:0];
                bus.sram_dq_oe  = 1'b1;
                bus.sram_we_n   = last;
            end
        end
    end

    // Capture each read halfword on the final cycle of its phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= 32'd0;
        end else if (in_phase && !op_wr && last) begin
            if (state == HIGH) begin
                rdata[31:16] <= bus.sram_dq_in;
            end else begin
                rdata[15:0] <= bus.sram_dq_in;
            end
        end
    end

    assign bus.read_data = rdata;
    assign bus.ready     = !((state == IDLE && req) || in_phase);

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a cycle-offset reference model.
// Optional build macro: SRAM_ALIGN_CHECK_EN (checks misalign_err path).
module tb_sram_access_ctrl;

    localparam int          W    = 5;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    sram_access_ctrl_if ifc ();

    sram_access_ctrl #(
        .WAIT_CYCLES(W),
        .DATA_BASE  (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Board SRAM: written on every clock edge while the strobe is low.
    logic [15:0] sram [0:255] = '{default: 16'h0};

    always @(posedge clk) begin
        if (!ifc.sram_we_n && ifc.sram_dq_oe)
            sram[ifc.sram_addr[7:0]] <= ifc.sram_dq_out;
    end

    assign ifc.sram_dq_in = sram[ifc.sram_addr[7:0]];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: m_k is the cycle index inside a transaction
    // (0 = idle, 1..W low half, W+1..2W high half, 2W+1 done).
    int          m_k = 0;
    bit          m_wr = 0;
    logic [31:0] m_addr = 0;
    logic [31:0] m_wd = 0;
    logic [31:0] m_rd = 0;
    bit          m_err = 0;
    logic [15:0] ref_mem [0:255] = '{default: 16'h0};

    int          cnt_we;
    int          cnt_rdy;
    logic [17:0] obs_lo;
    logic [17:0] obs_hi;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] wordof(logic [31:0] a);
        return 17'((a - BASE) >> 2);
    endfunction

    task automatic check_cycle();
        bit          in_ph;
        bit          hi;
        int          pos;
        logic [17:0] idx;
        logic [15:0] e_dq;
        in_ph = (m_k >= 1) && (m_k <= 2 * W);
        hi    = (m_k > W);
        pos   = (m_k >= 1) ? (m_k - 1) % W : 0;
        idx   = in_ph ? {wordof(m_addr), hi} : 18'd0;
        e_dq  = (in_ph && m_wr) ? (hi ? m_wd[31:16] : m_wd[15:0]) : 16'h0;
        chk("ready", ifc.ready,
            !((m_k == 0 && (ifc.rd_en || ifc.wr_en)) || in_ph));
        chk("sram_addr", ifc.sram_addr, idx);
        chk("sram_dq_oe", ifc.sram_dq_oe, in_ph && m_wr);
        chk("sram_we_n", ifc.sram_we_n, !(in_ph && m_wr && pos != W - 1));
        chk("sram_dq_out", ifc.sram_dq_out, e_dq);
        chk("read_data", ifc.read_data, m_rd);
`ifdef SRAM_ALIGN_CHECK_EN
        chk("misalign_err", ifc.misalign_err, m_err);
`endif
        if (!ifc.sram_we_n) cnt_we++;
        if (!ifc.ready) cnt_rdy++;
        if (m_k == 1) obs_lo = ifc.sram_addr;
        if (m_k == W + 1) obs_hi = ifc.sram_addr;
    endtask

    task automatic model_next(logic rd, logic wr, logic [31:0] a,
                              logic [31:0] d);
        bit          hi;
        int          pos;
        logic [7:0]  idx;
        hi  = (m_k > W);
        pos = (m_k >= 1) ? (m_k - 1) % W : 0;
        idx = 8'({wordof(m_addr), hi});
        if (!rst) begin
            m_k   = 0;
            m_rd  = 0;
            m_err = 0;
        end else if (m_k == 0) begin
            if (rd || wr) begin
                m_wr   = wr;
                m_addr = a;
                m_wd   = d;
                m_k    = 1;
`ifdef SRAM_ALIGN_CHECK_EN
                if (a[1:0] != 2'b00) begin
                    m_err = 1;
                    m_k   = 2 * W + 1;
                end
`endif
            end
        end else if (m_k == 2 * W + 1) begin
            m_k = 0;
        end else begin
            if (m_wr && pos == 0 && W > 1)
                ref_mem[idx] = hi ? m_wd[31:16] : m_wd[15:0];
            if (!m_wr && pos == W - 1) begin
                if (hi) m_rd[31:16] = ref_mem[idx];
                else    m_rd[15:0]  = ref_mem[idx];
            end
            m_k++;
        end
    endtask

    task automatic step(logic rd, logic wr, logic [31:0] a, logic [31:0] d);
        ifc.rd_en      = rd;
        ifc.wr_en      = wr;
        ifc.address    = a;
        ifc.write_data = d;
        @(negedge clk);
        check_cycle();
        model_next(rd, wr, a, d);
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(logic rd, logic wr, logic [31:0] a,
                           logic [31:0] d, bit toggle);
        cnt_we  = 0;
        cnt_rdy = 0;
        step(rd, wr, a, d);
        for (int i = 0; i < 2 * W; i++) begin
            if (toggle)
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom, $urandom);
            else
                step(1'b0, 1'b0, 32'd0, 32'd0);
        end
        step(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        ifc.rd_en      = 1'b0;
        ifc.wr_en      = 1'b0;
        ifc.address    = 32'd0;
        ifc.write_data = 32'd0;
        cnt_we  = 0;
        cnt_rdy = 0;
        obs_lo  = '0;
        obs_hi  = '0;

        repeat (3) step(1'b0, 1'b0, 32'd0, 32'd0);
        chk("rst_ready", ifc.ready, 1);
        chk("rst_we_n", ifc.sram_we_n, 1);
        chk("rst_addr", ifc.sram_addr, 0);
        chk("rst_rdata", ifc.read_data, 0);
        rst = 1'b1;
        repeat (2) step(1'b0, 1'b0, 32'd0, 32'd0);

        ifc.wr_en = 1'b1;
        #1;
        chk("ready_req_cycle", ifc.ready, 0);

        run_txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 0);
        chk("store_we_cycles", cnt_we, 8);
        chk("store_ready_low", cnt_rdy, 11);
        chk("sram0", sram[0], 16'hBEEF);
        chk("sram1", sram[1], 16'hDEAD);

        run_txn(1'b1, 1'b0, 32'd1024, 32'd0, 0);
        chk("load_1024", ifc.read_data, 32'hDEADBEEF);
        chk("load_ready_low", cnt_rdy, 11);

        run_txn(1'b0, 1'b1, 32'd1036, 32'hABCD1234, 0);
        run_txn(1'b1, 1'b0, 32'd1036, 32'd0, 0);
        chk("addr_lo_1036", obs_lo, 6);
        chk("addr_hi_1036", obs_hi, 7);
        chk("load_1036", ifc.read_data, 32'hABCD1234);

        run_txn(1'b0, 1'b1, 32'd1040, 32'h55667788, 0);
        chk("rdata_kept", ifc.read_data, 32'hABCD1234);

        run_txn(1'b1, 1'b1, 32'd1044, 32'h0BADF00D, 0);
        chk("both_lo", sram[10], 16'hF00D);
        chk("both_hi", sram[11], 16'h0BAD);

        run_txn(1'b0, 1'b1, 32'd1048, 32'h11223344, 1);
        chk("toggle_lo", sram[12], 16'h3344);
        chk("toggle_hi", sram[13], 16'h1122);

        run_txn(1'b1, 1'b0, 32'd1048, 32'd0, 0);
        run_txn(1'b1, 1'b0, 32'd1040, 32'd0, 0);
        chk("b2b_load", ifc.read_data, 32'h55667788);

        run_txn(1'b1, 1'b0, 32'd1026, 32'd0, 0);
`ifdef SRAM_ALIGN_CHECK_EN
        chk("misalign_flag", ifc.misalign_err, 1);
        chk("misalign_rdata", ifc.read_data, 32'h55667788);
        chk("misalign_ready_low", cnt_rdy, 1);
        chk("misalign_we", cnt_we, 0);
`else
        chk("unaligned_lo", obs_lo, 0);
        chk("unaligned_hi", obs_hi, 1);
        chk("unaligned_rdata", ifc.read_data, 32'hDEADBEEF);
`endif

        step(1'b0, 1'b1, 32'd1060, 32'hCAFEF00D);
        repeat (W + 1) step(1'b0, 1'b0, 32'd0, 32'd0);
        chk("pre_rst_we_n", ifc.sram_we_n, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_we_n", ifc.sram_we_n, 1);
        chk("mid_rst_oe", ifc.sram_dq_oe, 0);
        chk("mid_rst_addr", ifc.sram_addr, 0);
        chk("mid_rst_ready", ifc.ready, 1);
        chk("mid_rst_rdata", ifc.read_data, 0);
        m_k   = 0;
        m_rd  = 0;
        m_err = 0;
        cnt_we = 0;
        repeat (2) step(1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 32'd0, 32'd0);
        chk("post_rst_quiet", cnt_we, 0);

        run_txn(1'b1, 1'b0, 32'd1024, 32'd0, 0);
        chk("post_rst_load", ifc.read_data, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
